numarator_mod: RTL and testbench
================================

Name: numarator_mod

Overview:
- Parametrised up/down modulo counter; next generation of the fixed 2500-step interval counter.
- Adds configurable width and modulus, count enable, parallel load, and wrap or saturate mode.
- Adds a registered terminal-count pulse and an at-limit flag.
- Used as the timebase/interval counter in timer and PWM-style blocks; output feeds comparators downstream.

Parameters:
- WIDTH, 32, counter register width in bits.
- MODULUS, 2500, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- RESET_VAL, 0, value loaded by rst and clr; must be < MODULUS.
- PRESCALE, 1, enable divider ratio; used only when NUMARATOR_PRESCALER_EN is defined; must be ≥ 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- clr  input  1  synchronous clear, active-low.
- en  input  1  count enable, active-high.
- count_down  input  1  1 = decrement, 0 = increment.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap.
- load  input  1  synchronous parallel load, active-high.
- load_val  input  WIDTH  value to load.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, one cycle).
- at_limit  output  1  level flag: out == 0 when counting down, out == MODULUS-1 when counting up.

Behaviour:
- Reset: rst low → immediately, independent of clk: out = RESET_VAL, tc = 0, prescaler count = 0.
- at_limit is combinational from out and count_down; after reset it is valid.
- Priority per rising edge (rst high): clr low > load > en > hold.
- clr low: out ← RESET_VAL, tc ← 0, prescaler ← 0.
- load high: out ← load_val if load_val < MODULUS, else MODULUS-1 (clamped). tc ← 0. Load ignores en.
- Count step: occurs when en is high and (without prescaler) on every such edge.
- Up count, out < MODULUS-1: out ← out+1, tc ← 0.
- Up count, out == MODULUS-1, wrap mode: out ← 0, tc ← 1.
- Up count, out == MODULUS-1, saturate mode: out holds, tc ← 1 on the first blocked step only; stays 0 while held.
- Down count, out > 0: out ← out-1, tc ← 0.
- Down count, out == 0, wrap mode: out ← MODULUS-1, tc ← 1.
- Down count, out == 0, saturate mode: out holds, tc ← 1 on the first blocked step only.
- No step (en low, no load, clr high): out holds, tc ← 0.
- tc timing: tc is high in exactly the cycle in which out first shows the wrapped (or first-saturated) value. Zero latency relative to out.
- Saturation memo: a 1-bit sat_hit register tracks "already pulsed". It is cleared by any load, clr, direction change, or successful step.
- X/Z on count_down or sat_mode: out holds, tc ← 0. Simulation safety only; not synthesised as a state.
- Arithmetic: all comparisons unsigned, WIDTH bits; no intermediate overflow. If MODULUS = 2^WIDTH, MODULUS-1 is all-ones.
- Mid-operation reset: rst assertion during any state returns to reset values. Deassertion takes effect at the next edge with no spurious tc.
- Simultaneous load and en: load wins; no tc.
- Simultaneous clr and load: clr wins.

Optional Feature:
- Macro: NUMARATOR_PRESCALER_EN.
- Defined:
  - An internal counter of width $clog2(PRESCALE)+1 increments on each en-high edge.
  - A count step occurs only when the prescaler reaches PRESCALE-1; the prescaler then returns to 0.
  - load and clr reset the prescaler to 0. en low freezes the prescaler.
  - PRESCALE = 1 is equivalent to no prescaler.
- Not defined: PRESCALE is ignored; each en-high edge is a step; no prescaler logic is generated.

Test Plan:
- Reset/clear: WIDTH=32, MODULUS=2500. Assert rst low mid-count at out=1234 → out=0, tc=0 with no clk edge. Then clr low one cycle at out=17 → out=0 next edge.
- Up wrap: load 2498, en=1, up, wrap. Sequence out=2498,2499,0,1; tc=1 only in the cycle out=0; at_limit=1 only while out=2499.
- Down wrap: load 1, down, wrap. Sequence out=1,0,2499; tc=1 only when out=2499. Then en=0 for 5 cycles → out holds 2499, tc=0.
- Saturate: sat_mode=1, up, load 2497. Sequence out=2497,2498,2499,2499,2499; tc=1 one cycle at the first hold only. Switch count_down=1 → out=2498 next edge, tc=0.
- Load clamp and priority:
  - load_val=5000 → out=2499.
  - load=1 and en=1 with load_val=10 → out=10, tc=0.
  - clr low with load=1 → out=RESET_VAL.
- Prescaler (NUMARATOR_PRESCALER_EN, PRESCALE=4): en=1 continuous from out=0 up → out increments every 4th edge (0,0,0,1,1,1,1,2). A load at prescaler=2 restarts the 4-cycle spacing.

Source files
------------

// File: rtl/numarator_mod.sv
// Up/down modulo counter with parallel load, wrap/saturate mode and a registered terminal-count pulse.
// Define NUMARATOR_PRESCALER_EN to divide count-enable by PRESCALE before it reaches the counter.
module numarator_mod #(
    parameter int unsigned     WIDTH     = 32,
    parameter longint unsigned MODULUS   = 2500,
    parameter longint unsigned RESET_VAL = 0,
    parameter int unsigned     PRESCALE  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             count_down_i,
    input  logic             sat_mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] out_o,
    output logic             tc_o,
    output logic             at_limit_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    if (MODULUS < 2 || RESET_VAL >= MODULUS || PRESCALE < 1 ||
        MODULUS > (64'd1 << WIDTH)) begin : g_param_check
        $error("numarator_mod: illegal parameter set");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             hit_q, hit_d;
    logic             dir_q;
    logic             step_tick;
    logic             ctrl_unknown;

`ifndef SYNTHESIS
    assign ctrl_unknown = $isunknown({count_down_i, sat_mode_i});
`else
    assign ctrl_unknown = 1'b0;
`endif

`ifdef NUMARATOR_PRESCALER_EN
    localparam int unsigned     PW       = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign step_tick = en_i && (presc_q == PRE_LAST);

    always_comb begin
        presc_d = presc_q;
        if (!clr_i || load_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = step_tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign step_tick = en_i;
`endif

    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        hit_d = hit_q;
        // A direction change re-arms the saturation pulse.
        if (count_down_i != dir_q) begin
            hit_d = 1'b0;
        end
        if (!clr_i) begin
            out_d = RST_VAL;
            hit_d = 1'b0;
        end else if (load_i) begin
            out_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
            hit_d = 1'b0;
        end else if (step_tick && !ctrl_unknown) begin
            if (!count_down_i) begin
                if (out_q != MAX_VAL) begin
                    out_d = out_q + WIDTH'(1);
                    hit_d = 1'b0;
                end else if (!sat_mode_i) begin
                    out_d = '0;
                    tc_d  = 1'b1;
                    hit_d = 1'b0;
                end else begin
                    tc_d  = !hit_d;
                    hit_d = 1'b1;
                end
            end else begin
                if (out_q != '0) begin
                    out_d = out_q - WIDTH'(1);
                    hit_d = 1'b0;
                end else if (!sat_mode_i) begin
                    out_d = MAX_VAL;
                    tc_d  = 1'b1;
                    hit_d = 1'b0;
                end else begin
                    tc_d  = !hit_d;
                    hit_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_q <= RST_VAL;
            tc_q  <= 1'b0;
            hit_q <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            hit_q <= hit_d;
            dir_q <= count_down_i;
        end
    end

    assign out_o      = out_q;
    assign tc_o       = tc_q;
    assign at_limit_o = count_down_i ? (out_q == '0) : (out_q == MAX_VAL);

endmodule

// File: tb/tb_numarator_mod.sv
// Self-checking bench for numarator_mod: directed vector table, corner sequences, random vs. reference model.
module tb_numarator_mod;

    localparam int unsigned W   = 32;
    localparam longint      MOD = 2500;
    localparam longint      RV  = 0;
`ifdef NUMARATOR_PRESCALER_EN
    localparam int unsigned PRE = 4;
`else
    localparam int unsigned PRE = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b1;
    logic         en = 1'b0;
    logic         down = 1'b0;
    logic         sat = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] lval = '0;
    logic [W-1:0] out;
    logic         tc;
    logic         lim;

    int total = 0;
    int bad   = 0;

    numarator_mod #(
        .WIDTH(W), .MODULUS(MOD), .RESET_VAL(RV), .PRESCALE(PRE)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en),
        .count_down_i(down), .sat_mode_i(sat), .load_i(load),
        .load_val_i(lval), .out_o(out), .tc_o(tc), .at_limit_o(lim)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the counter value.
    longint m_out;
    bit     m_tc, m_hit, m_dir;
    int     m_pre;

    task automatic model_reset();
        m_out = RV; m_tc = 0; m_hit = 0; m_dir = 0; m_pre = 0;
    endtask

    task automatic model_edge();
        bit do_step;
        if (down != m_dir) m_hit = 0;
        m_dir = down;
        m_tc  = 0;
        if (!clr) begin
            m_out = RV; m_hit = 0; m_pre = 0;
        end else if (load) begin
            m_out = (longint'(lval) >= MOD) ? MOD - 1 : longint'(lval);
            m_hit = 0; m_pre = 0;
        end else if (en) begin
            do_step = 1;
            if (m_pre == PRE - 1) m_pre = 0;
            else begin m_pre++; do_step = 0; end
            if (do_step) begin
                if (!down) begin
                    if (m_out < MOD - 1) begin m_out++; m_hit = 0; end
                    else if (!sat) begin m_out = 0; m_tc = 1; m_hit = 0; end
                    else begin m_tc = !m_hit; m_hit = 1; end
                end else begin
                    if (m_out > 0) begin m_out--; m_hit = 0; end
                    else if (!sat) begin m_out = MOD - 1; m_tc = 1; m_hit = 0; end
                    else begin m_tc = !m_hit; m_hit = 1; end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; clr = 1; en = 0; load = 0; down = 0; sat = 0; lval = '0;
        tick();
        rst = 1;
    endtask

    typedef struct {
        bit     clr_n; bit load; int unsigned lv; bit en; bit dn; bit st;
        longint e_out; bit e_tc; bit e_lim;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit c, bit l, int unsigned v, bit e, bit d, bit s,
                                longint eo, bit et, bit el);
        vec_t r;
        r.clr_n = c; r.load = l; r.lv = v; r.en = e; r.dn = d; r.st = s;
        r.e_out = eo; r.e_tc = et; r.e_lim = el;
        return r;
    endfunction

    initial begin
        int pexp[8];
        do_reset();

        // Async reset mid-count, no clock edge involved.
        load = 1; lval = 1232; en = 1; tick();
        load = 0; tick(); tick();
        check("pre_reset_out", out, 1234);
        #3 rst = 0; #1;
        check("async_rst_out", out, 0);
        check("async_rst_tc", tc, 0);
        down = 1; #1;
        check("rst_at_limit_down", lim, 1);
        down = 0; #1;
        check("rst_at_limit_up", lim, 0);
        #1 rst = 1;
        tick();
        check("rst_release_out", out, 1);
        check("rst_release_tc", tc, 0);

        // Async reset clears a live tc pulse.
        load = 1; lval = 2499; tick();
        load = 0; tick();
        check("wrap_tc_before_rst", tc, 1);
        #3 rst = 0; #1;
        check("async_rst_tc_live", tc, 0);
        check("async_rst_out_live", out, 0);
        #2 rst = 1;

        // Synchronous clear.
        en = 0; load = 1; lval = 17; tick();
        load = 0; check("clr_pre_out", out, 17);
        clr = 0; en = 1; tick();
        check("clr_out", out, 0);
        check("clr_tc", tc, 0);
        clr = 1; en = 0;

`ifdef NUMARATOR_PRESCALER_EN
        do_reset();
        pexp = '{0, 0, 0, 1, 1, 1, 1, 2};
        en = 1; down = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("presc_seq[%0d]", i), out, pexp[i]);
        end
        tick(); tick();
        load = 1; lval = 100; tick();
        load = 0;
        check("presc_load", out, 100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("presc_after_load[%0d]", i), out, (i == 3) ? 101 : 100);
        end
        en = 0;
`else
        pexp = '{default: 0};
        do_reset();
        //          clr ld val   en dn st   out  tc lim
        vecs.push_back(mk(1, 1, 2498, 1, 0, 0, 2498, 0, 0));
        vecs.push_back(mk(1, 0, 0,    1, 0, 0, 2499, 0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 0, 0, 0,    1, 0));
        vecs.push_back(mk(1, 0, 0,    1, 0, 0, 1,    0, 0));
        vecs.push_back(mk(1, 1, 1,    0, 1, 0, 1,    0, 0));
        vecs.push_back(mk(1, 0, 0,    1, 1, 0, 0,    0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 1, 0, 2499, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 0, 2499, 0, 0));
        vecs.push_back(mk(1, 1, 2497, 0, 0, 1, 2497, 0, 0));
        vecs.push_back(mk(1, 0, 0,    1, 0, 1, 2498, 0, 0));
        vecs.push_back(mk(1, 0, 0,    1, 0, 1, 2499, 0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 0, 1, 2499, 1, 1));
        vecs.push_back(mk(1, 0, 0,    1, 0, 1, 2499, 0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 0, 1, 2499, 0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 1, 1, 2498, 0, 0));
        vecs.push_back(mk(1, 1, 5000, 0, 0, 0, 2499, 0, 1));
        vecs.push_back(mk(1, 1, 10,   1, 0, 0, 10,   0, 0));
        vecs.push_back(mk(0, 1, 77,   1, 0, 0, 0,    0, 0));
        vecs.push_back(mk(1, 0, 0,    1, 0, 0, 1,    0, 0));
        vecs.push_back(mk(1, 1, 0,    0, 1, 1, 0,    0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 1, 1, 0,    1, 1));
        vecs.push_back(mk(1, 0, 0,    1, 1, 1, 0,    0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 0, 1, 1,    0, 0));
        vecs.push_back(mk(1, 0, 0,    1, 1, 1, 0,    0, 1));
        vecs.push_back(mk(1, 0, 0,    1, 1, 1, 0,    1, 1));
        foreach (vecs[i]) begin
            clr = vecs[i].clr_n; load = vecs[i].load; lval = vecs[i].lv;
            en = vecs[i].en; down = vecs[i].dn; sat = vecs[i].st;
            tick();
            check($sformatf("vec[%0d].out", i), out, vecs[i].e_out);
            check($sformatf("vec[%0d].tc", i), tc, vecs[i].e_tc);
            check($sformatf("vec[%0d].at_limit", i), lim, vecs[i].e_lim);
        end
`endif

        // Randomised run against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            clr  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            load = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 6))
                0: lval = 0;
                1: lval = 1;
                2: lval = 2498;
                3: lval = 2499;
                4: lval = 2500;
                5: lval = $urandom;
                default: lval = $urandom_range(0, 2499);
            endcase
            en = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 5) down = ~down;
            if ($urandom_range(0, 99) < 5) sat = ~sat;
            model_edge();
            tick();
            check("rand_out", out, m_out);
            check("rand_tc", tc, m_tc);
            check("rand_at_limit", lim, down ? (m_out == 0) : (m_out == MOD - 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
